// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's tour move sequencer.
// decode_move turns a solver move code into its vertical and horizontal legs.
package tour_pkg;

   typedef enum logic [2:0] {
      IDLE,
      VERT,
      VERT_WT,
      HORZ,
      HORZ_WT
   } state_t;

   localparam logic [3:0] OP_MOVE     = 4'h4;
   localparam logic [3:0] OP_MOVE_FAN = 4'h5;

   localparam logic [7:0] HDG_N = 8'h00;
   localparam logic [7:0] HDG_W = 8'h3F;
   localparam logic [7:0] HDG_S = 8'h7F;
   localparam logic [7:0] HDG_E = 8'hBF;

   localparam logic [7:0] POS_ACK  = 8'hA5;
   localparam logic [7:0] TOUR_ACK = 8'h5A;

   // Result is {vert_cmd, horz_cmd}.
   function automatic logic [31:0] decode_move(input logic [2:0] move);
      logic       dx_pos, dy_pos;
      logic [3:0] dx_mag, dy_mag;
      dx_pos = 1'b1;
      dy_pos = 1'b1;
      dx_mag = 4'd1;
      dy_mag = 4'd2;
      case (move)
         3'd0: begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
         3'd1: begin dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
         3'd2: begin dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1; end
         3'd3: begin dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1; end
         3'd4: begin dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2; end
         3'd5: begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2; end
         3'd6: begin dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1; end
         default: begin dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1; end
      endcase
      return {OP_MOVE,     (dy_pos ? HDG_N : HDG_S), dy_mag,
              OP_MOVE_FAN, (dx_pos ? HDG_E : HDG_W), dx_mag};
   endfunction

endpackage

// File: rtl/tour_move_sequencer.sv
// Turns a solved knight's tour into vertical/horizontal cmd_proc legs, and
// passes the UART command path straight through whenever no tour is running.
module tour_move_sequencer
   import tour_pkg::*;
#(
   parameter int NUM_MOVES = 24,
   parameter int IDX_W     = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_tour,
   input  logic [2:0]       move,
   output logic [IDX_W-1:0] mv_indx,
   input  logic [15:0]      cmd_UART,
   input  logic             cmd_rdy_UART,
   input  logic             clr_cmd_rdy,
   input  logic             send_resp,
   output logic [15:0]      cmd,
   output logic             cmd_rdy,
   output logic [7:0]       resp,
   output logic             tour_active
);

   state_t           state, nxt_state;
   logic [IDX_W-1:0] nxt_indx;
   logic [15:0]      vert_cmd, horz_cmd;
   logic             last_move;

   assign {vert_cmd, horz_cmd} = decode_move(move);
   assign last_move   = (mv_indx == IDX_W'(NUM_MOVES - 1));
   assign tour_active = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mv_indx <= '0;
      end else begin
         state   <= nxt_state;
         mv_indx <= nxt_indx;
      end
   end

   // In the active states the UART path is simply not selected, so any
   // command it offers meanwhile is dropped.
   always_comb begin
      nxt_state = state;
      nxt_indx  = mv_indx;
      cmd       = cmd_UART;
      cmd_rdy   = cmd_rdy_UART;
      resp      = POS_ACK;
      case (state)
         IDLE: begin
            if (start_tour) begin
               nxt_state = VERT;
               nxt_indx  = '0;
            end
         end
         VERT: begin
            cmd     = vert_cmd;
            cmd_rdy = 1'b1;
            resp    = TOUR_ACK;
            if (clr_cmd_rdy) nxt_state = VERT_WT;
         end
         VERT_WT: begin
            cmd     = vert_cmd;
            cmd_rdy = 1'b0;
            resp    = TOUR_ACK;
            if (send_resp) nxt_state = HORZ;
         end
         HORZ: begin
            cmd     = horz_cmd;
            cmd_rdy = 1'b1;
            resp    = TOUR_ACK;
            if (clr_cmd_rdy) nxt_state = HORZ_WT;
         end
         HORZ_WT: begin
            cmd     = horz_cmd;
            cmd_rdy = 1'b0;
            // Final leg acks positively so the host sees tour completion.
            resp    = last_move ? POS_ACK : TOUR_ACK;
            if (send_resp) begin
               if (last_move) begin
                  nxt_state = IDLE;
                  nxt_indx  = '0;
               end else begin
                  nxt_state = VERT;
                  nxt_indx  = mv_indx + IDX_W'(1);
               end
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

endmodule
